// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: opcodes and FSM state encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending ALU commands.
// Push is ignored while full and pop is ignored while empty, so the
// pointers and count can never wrap into an inconsistent state.
module alu_cmd_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Storage array; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Command-side driver for the low-area ALU: buffers requests, issues the ALU
// load pulse, holds the opcode during evaluation and returns the captured result.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_opt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [2:0]       res_opt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opt,
    output logic             alu_load,
    input  logic [WIDTH-1:0] alu_dout,
    input  logic             alu_done
);

    localparam int EW = 2 * WIDTH + 3;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [2:0]       op_q;
    logic [EW-1:0]    head_s;
    logic [WIDTH-1:0] head_a_s;
    logic [WIDTH-1:0] head_b_s;
    logic [2:0]       head_opt_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             load_s;
    logic             capture_s;
    logic             clear_s;

    // cmd_ready only reflects fullness; a same-cycle pop does not free a slot early.
    assign cmd_ready = !fifo_full_s;

    assign head_a_s   = head_s[EW-1 -: WIDTH];
    assign head_b_s   = head_s[3 +: WIDTH];
    assign head_opt_s = head_s[2:0];

    alu_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && !fifo_full_s),
        .wdata ({cmd_a, cmd_b, cmd_opt}),
        .pop   (load_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state logic: a load (and pop) happens from IDLE, or from RESP once the result is taken.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        capture_s   = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!fifo_empty_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = S_EXEC;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_EXEC: begin
                if (alu_done) begin
                    capture_s   = 1'b1;
                    state_nxt_s = S_RESP;
                end else begin
                    state_nxt_s = S_EXEC;
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    clear_s = 1'b1;
                    if (!fifo_empty_s) begin
                        load_s      = 1'b1;
                        state_nxt_s = S_EXEC;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // ALU pin drive: operands only during the load pulse, opcode held from op_q otherwise.
    always_comb begin
        alu_load = load_s;
        if (load_s) begin
            alu_a   = head_a_s;
            alu_b   = head_b_s;
            alu_opt = head_opt_s;
        end else begin
            alu_a   = {WIDTH{1'b0}};
            alu_b   = {WIDTH{1'b0}};
            alu_opt = op_q;
        end
    end

    // State, latched opcode and result registers; reset drops any in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            op_q      <= OP_ADD;
            res_valid <= 1'b0;
            res_data  <= {WIDTH{1'b0}};
            res_opt   <= 3'b000;
        end else begin
            state_r <= state_nxt_s;
            if (load_s) begin
                op_q <= head_opt_s;
            end
            if (capture_s) begin
                res_valid <= 1'b1;
                res_data  <= alu_dout;
                res_opt   <= op_q;
            end else if (clear_s) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver with a behavioural ALU attached.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_opt;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_opt;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_opt;
    logic       alu_load;
    logic [7:0] alu_dout;
    logic       alu_done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [10:0] sb[$];
    int          pop_cyc[$];
    logic        prev_load = 1'b0;

    alu_cmd_driver #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_opt   (cmd_opt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_opt   (res_opt),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_opt   (alu_opt),
        .alu_load  (alu_load),
        .alu_dout  (alu_dout),
        .alu_done  (alu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: latches operands on load, evaluates with the current opcode.
    logic [7:0] la;
    logic [7:0] lb;
    always @(posedge clk) begin
        if (alu_load) begin
            la <= alu_a;
            lb <= alu_b;
        end
    end
    always_comb begin
        alu_dout = 8'h00;
        case (alu_opt)
            3'b000:  alu_dout = la + lb;
            3'b001:  alu_dout = la - lb;
            3'b010:  alu_dout = la & lb;
            3'b011:  alu_dout = la | lb;
            3'b100:  alu_dout = la ^ lb;
            3'b101:  alu_dout = {la[6:0], 1'b0};
            3'b110:  alu_dout = {1'b0, la[7:1]};
            default: alu_dout = ($signed(la) < $signed(lb)) ? 8'h01 : 8'h00;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every consumed result must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got data 0x%0h opt %0d with nothing expected", res_data, res_opt);
            end else begin
                logic [10:0] e;
                e = sb.pop_front();
                chk("res_data", {24'h0, res_data}, {24'h0, e[10:3]});
                chk("res_opt", {29'h0, res_opt}, {29'h0, e[2:0]});
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Load pulse must never be high on two consecutive cycles.
    always @(negedge clk) begin
        if (!rst && alu_load) begin
            chk("load_single_cycle", {31'h0, prev_load}, 32'h0);
        end
        prev_load <= alu_load;
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [7:0] exp);
        bit acc;
        acc = 1'b0;
        cmd_a = a; cmd_b = b; cmd_opt = op; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            if (acc) sb.push_back({exp, op});
        end
        #1;
        cmd_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: command not accepted, expected acceptance");
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !res_valid) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results still outstanding, expected 0", sb.size());
        end
    endtask

    logic [7:0] bp_a [6] = '{8'h10, 8'h50, 8'hCC, 8'h12, 8'hFF, 8'h01};
    logic [7:0] bp_b [6] = '{8'h20, 8'h10, 8'h0F, 8'h21, 8'h0F, 8'h01};
    logic [2:0] bp_o [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
    logic [7:0] bp_e [6] = '{8'h30, 8'h40, 8'h0C, 8'h33, 8'hF0, 8'h02};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int loads;
        int acc_cnt;
        int idx;
        bit acc;
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_opt = 3'b000;
        res_ready = 1'b1; alu_done = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        // Reset state: {cmd_ready,res_valid,alu_load,res_data,res_opt,alu_a,alu_b,alu_opt}
        chk("reset_state", {cmd_ready, res_valid, alu_load, res_data, res_opt, alu_a, alu_b, alu_opt},
            {1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 8'h00, 8'h00, 3'b000});
        rst = 1'b0;
        @(posedge clk); #1;

        // 1. Single add with latency and load-pulse count.
        cmd_a = 8'h05; cmd_b = 8'h03; cmd_opt = OP_ADD; cmd_valid = 1'b1;
        chk("t1_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        sb.push_back({8'h08, OP_ADD});
        edges = 0; loads = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            edges++;
            cmd_valid = 1'b0;
            if (alu_load) loads++;
            if (res_valid) break;
        end
        chk("t1_latency_edges", edges, 3);
        chk("t1_load_cycles", loads, 1);
        wait_drain();

        // 2. Sub and signed compare.
        send(8'h03, 8'h05, OP_SUB, 8'hFE);
        send(8'h03, 8'h05, OP_SLT, 8'h01);
        send(8'h05, 8'h03, OP_SLT, 8'h00);
        wait_drain();

        // 3. Back-pressure: six back-to-back pushes, five accepted.
        res_ready = 1'b0;
        acc_cnt = 0; idx = 0;
        cmd_valid = 1'b1;
        cmd_a = bp_a[0]; cmd_b = bp_b[0]; cmd_opt = bp_o[0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            if (acc) begin
                sb.push_back({bp_e[idx], bp_o[idx]});
                acc_cnt++;
                idx++;
            end
            #1;
            cmd_a = bp_a[idx]; cmd_b = bp_b[idx]; cmd_opt = bp_o[idx];
        end
        cmd_valid = 1'b0;
        chk("t3_accepted", acc_cnt, 5);
        chk("t3_cmd_ready_low", {31'h0, cmd_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold", {res_valid, res_data, res_opt}, {1'b1, 8'h30, OP_ADD});
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        wait_drain();

        // 4. Streaming: four results spaced two cycles apart.
        pop_cyc.delete();
        send(8'hF0, 8'h0F, OP_AND, 8'h00);
        send(8'hF0, 8'h0F, OP_OR,  8'hFF);
        send(8'hAA, 8'hFF, OP_XOR, 8'h55);
        send(8'h81, 8'h00, OP_SHL, 8'h02);
        wait_drain();
        chk("t4_result_count", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("t4_spacing", pop_cyc[i] - pop_cyc[i-1], 2);
        end

        // 5. Reset while EXEC is stalled with two commands queued.
        alu_done = 1'b0;
        send(8'h11, 8'h22, OP_ADD, 8'h33);
        send(8'h44, 8'h11, OP_SUB, 8'h33);
        send(8'h0F, 8'hF0, OP_OR,  8'hFF);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_after_reset", {res_valid, cmd_ready, alu_load}, {1'b0, 1'b1, 1'b0});
        alu_done = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t5_no_stale", {31'h0, res_valid}, 32'h0);
        send(8'h01, 8'h01, OP_ADD, 8'h02);
        wait_drain();

        // 6. Done stall: opcode held in EXEC, capture only once done rises.
        alu_done = 1'b0;
        send(8'h07, 8'h02, OP_SUB, 8'h05);
        chk("t6_load_pins", {alu_load, alu_a, alu_b, alu_opt}, {1'b1, 8'h07, 8'h02, OP_SUB});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t6_stall_pins", {alu_load, alu_a, alu_b, alu_opt, res_valid},
                {1'b0, 8'h00, 8'h00, OP_SUB, 1'b0});
        end
        alu_done = 1'b1;
        @(posedge clk); #1;
        chk("t6_capture", {res_valid, res_data, res_opt}, {1'b1, 8'h05, OP_SUB});
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
